// File: rtl/mpu_bus_master.sv
// Burst bus initiator for the ChronoCube MPU port: turns one burst command into
// single-word MPU strobes with auto-incrementing address and streamed data.
module mpu_bus_master #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  _reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [1:0]            cmd_be,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rdata_valid,
  input  logic                  rdata_ready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  mpu_en,
  output logic                  mpu_rd,
  output logic                  mpu_wr,
  output logic [1:0]            mpu_be,
  output logic [ADDR_WIDTH-1:0] mpu_addr,
  output logic [DATA_WIDTH-1:0] mpu_wdata,
  input  logic [DATA_WIDTH-1:0] mpu_rdata
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WR_WAIT   = 3'd1;
  localparam logic [2:0] ST_WR_STROBE = 3'd2;
  localparam logic [2:0] ST_RD_STROBE = 3'd3;
  localparam logic [2:0] ST_RD_HOLD   = 3'd4;

  localparam int WAIT_W = (RD_LATENCY > 0) ? $clog2(RD_LATENCY + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(RD_LATENCY);

  logic [2:0]            state_q,  state_nx;
  logic [ADDR_WIDTH-1:0] addr_q,   addr_nx;
  logic [LEN_WIDTH-1:0]  cnt_q,    cnt_nx;
  logic [1:0]            be_q,     be_nx;
  logic [WAIT_W-1:0]     wait_q,   wait_nx;
  logic                  load_wdata;
  logic                  cap_rdata;
  logic                  wr_strobe_nx;
  logic                  rd_strobe_nx;

  always_comb begin
    state_nx   = state_q;
    addr_nx    = addr_q;
    cnt_nx     = cnt_q;
    be_nx      = be_q;
    wait_nx    = wait_q;
    load_wdata = 1'b0;
    cap_rdata  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_nx  = cmd_addr;
          cnt_nx   = cmd_len;
          be_nx    = cmd_be;
          wait_nx  = WAIT_LOAD;
          state_nx = cmd_wr ? ST_WR_WAIT : ST_RD_STROBE;
        end
      end
      ST_WR_WAIT: begin
        if (wdata_valid && wdata_ready) begin
          load_wdata = 1'b1;
          state_nx   = ST_WR_STROBE;
        end
      end
      ST_WR_STROBE: begin
        if (cnt_q == '0) begin
          state_nx = ST_IDLE;
        end else begin
          addr_nx  = addr_q + ADDR_WIDTH'(1);
          cnt_nx   = cnt_q - LEN_WIDTH'(1);
          state_nx = ST_WR_WAIT;
        end
      end
      ST_RD_STROBE: begin
        if (wait_q == '0) begin
          cap_rdata = 1'b1;
          state_nx  = ST_RD_HOLD;
        end else begin
          wait_nx = wait_q - WAIT_W'(1);
        end
      end
      ST_RD_HOLD: begin
        if (rdata_ready) begin
          if (cnt_q == '0) begin
            state_nx = ST_IDLE;
          end else begin
            addr_nx  = addr_q + ADDR_WIDTH'(1);
            cnt_nx   = cnt_q - LEN_WIDTH'(1);
            wait_nx  = WAIT_LOAD;
            state_nx = ST_RD_STROBE;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign wr_strobe_nx = (state_nx == ST_WR_STROBE);
  assign rd_strobe_nx = (state_nx == ST_RD_STROBE);

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      be_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_nx;
      addr_q  <= addr_nx;
      cnt_q   <= cnt_nx;
      be_q    <= be_nx;
      wait_q  <= wait_nx;
    end
  end

  // Every output is decoded from the next state so it lines up with state_q.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      cmd_ready   <= 1'b0;
      wdata_ready <= 1'b0;
      rdata_valid <= 1'b0;
      rdata       <= '0;
      busy        <= 1'b0;
      mpu_en      <= 1'b0;
      mpu_rd      <= 1'b0;
      mpu_wr      <= 1'b0;
      mpu_be      <= '0;
      mpu_addr    <= '0;
      mpu_wdata   <= '0;
    end else begin
      cmd_ready   <= (state_nx == ST_IDLE);
      wdata_ready <= (state_nx == ST_WR_WAIT);
      rdata_valid <= (state_nx == ST_RD_HOLD);
      busy        <= (state_nx != ST_IDLE);
      mpu_en      <= wr_strobe_nx || rd_strobe_nx;
      mpu_rd      <= rd_strobe_nx;
      mpu_wr      <= wr_strobe_nx;
      mpu_be      <= (wr_strobe_nx || rd_strobe_nx) ? be_nx : 2'b00;
      if (wr_strobe_nx || rd_strobe_nx)
        mpu_addr <= addr_nx;
      if (load_wdata)
        mpu_wdata <= wdata;
      if (cap_rdata)
        rdata <= mpu_rdata;
    end
  end

endmodule

// File: tb/tb_mpu_bus_master.sv
// Directed bench for mpu_bus_master: a transaction-level model predicts every
// MPU strobe and read word, and a per-cycle monitor compares the DUT against it.
module tb_mpu_bus_master;

  localparam int RDL = 1;

  logic        clk = 1'b0;
  logic        _reset;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [1:0]  cmd_be;
  logic        wdata_valid, wdata_ready;
  logic [15:0] wdata;
  logic        rdata_valid, rdata_ready;
  logic [15:0] rdata;
  logic        busy, mpu_en, mpu_rd, mpu_wr;
  logic [1:0]  mpu_be;
  logic [15:0] mpu_addr, mpu_wdata, mpu_rdata;

  always #5 clk = ~clk;

  mpu_bus_master #(
    .ADDR_WIDTH(16), .DATA_WIDTH(16), .LEN_WIDTH(8), .RD_LATENCY(RDL)
  ) dut (
    .clk(clk), ._reset(_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_be(cmd_be),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .busy(busy), .mpu_en(mpu_en), .mpu_rd(mpu_rd), .mpu_wr(mpu_wr),
    .mpu_be(mpu_be), .mpu_addr(mpu_addr), .mpu_wdata(mpu_wdata),
    .mpu_rdata(mpu_rdata)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM responder: returns 0xA000+addr the cycle after a read strobe.
  always @(posedge clk or negedge _reset) begin
    if (!_reset) mpu_rdata <= 16'h0;
    else         mpu_rdata <= mpu_rd ? 16'(16'hA000 + mpu_addr) : 16'h0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
    logic [1:0]  be;
  } xact_t;

  xact_t       exp_wr[$];
  xact_t       exp_rd[$];
  logic [15:0] exp_rdata[$];
  logic [15:0] obs_wr_addr[$];
  logic [15:0] obs_wr_data[$];
  int          wr_cyc[$];
  logic [15:0] obs_rd_addr[$];
  logic [15:0] obs_rdata[$];

  function automatic logic [15:0] wd(input int i);
    logic [31:0] t;
    t = (i + 1) * 32'h1111;
    return t[15:0];
  endfunction

  function automatic logic [15:0] rd_model(input logic [15:0] a);
    return 16'(16'hA000 + a);
  endfunction

  // Per-cycle monitor, sampled on the falling edge.
  logic        prev_rd, prev_wr, prev_rv, prev_hs;
  logic [15:0] prev_rdata, rd_addr0;
  int          rd_len;

  always @(negedge clk) begin
    xact_t e;
    if (!_reset) begin
      prev_rd = 1'b0; prev_wr = 1'b0; prev_rv = 1'b0; prev_hs = 1'b0; rd_len = 0;
    end else begin
      chk("rd_wr_exclusive", {31'b0, mpu_rd & mpu_wr}, 0);
      chk("en_matches_strobes", {31'b0, mpu_en}, {31'b0, mpu_rd | mpu_wr});
      if (!(mpu_rd || mpu_wr)) chk("be_zero_no_strobe", {30'b0, mpu_be}, 0);
      if (wdata_ready) chk("no_strobe_in_wr_wait", {31'b0, mpu_rd | mpu_wr}, 0);
      if (rdata_valid) chk("no_rd_during_hold", {31'b0, mpu_rd}, 0);
      if (cmd_ready) chk("idle_not_busy", {31'b0, busy}, 0);
      if (prev_hs) chk("rvalid_drops_after_hs", {31'b0, rdata_valid}, 0);
      if (mpu_wr) begin
        chk("wr_single_cycle", {31'b0, prev_wr}, 0);
        if (exp_wr.size() == 0) fail_now("unexpected_wr_strobe");
        else begin
          e = exp_wr.pop_front();
          chk("wr_addr", {16'b0, mpu_addr}, {16'b0, e.a});
          chk("wr_data", {16'b0, mpu_wdata}, {16'b0, e.d});
          chk("wr_be", {30'b0, mpu_be}, {30'b0, e.be});
        end
        obs_wr_addr.push_back(mpu_addr);
        obs_wr_data.push_back(mpu_wdata);
        wr_cyc.push_back(cyc);
      end
      if (mpu_rd && !prev_rd) begin
        if (exp_rd.size() == 0) fail_now("unexpected_rd_strobe");
        else begin
          e = exp_rd.pop_front();
          chk("rd_addr", {16'b0, mpu_addr}, {16'b0, e.a});
          chk("rd_be", {30'b0, mpu_be}, {30'b0, e.be});
        end
        obs_rd_addr.push_back(mpu_addr);
        rd_len = 1;
        rd_addr0 = mpu_addr;
      end else if (mpu_rd) begin
        rd_len++;
        chk("rd_addr_stable", {16'b0, mpu_addr}, {16'b0, rd_addr0});
      end
      if (!mpu_rd && prev_rd) chk("rd_strobe_len", rd_len, RDL + 1);
      if (rdata_valid && prev_rv && !prev_hs)
        chk("rdata_stable", {16'b0, rdata}, {16'b0, prev_rdata});
      if (rdata_valid && rdata_ready) begin
        if (exp_rdata.size() == 0) fail_now("unexpected_rdata");
        else chk("rdata_value", {16'b0, rdata}, {16'b0, exp_rdata.pop_front()});
        obs_rdata.push_back(rdata);
      end
      prev_rd = mpu_rd; prev_wr = mpu_wr; prev_rv = rdata_valid;
      prev_hs = rdata_valid && rdata_ready;
      prev_rdata = rdata;
    end
  end

  task automatic clear_logs();
    obs_wr_addr.delete(); obs_wr_data.delete(); wr_cyc.delete();
    obs_rd_addr.delete(); obs_rdata.delete();
  endtask

  // All stimulus tasks start and end 2 time units after a rising edge.
  task automatic send_cmd(input logic wr, input logic [15:0] a, input logic [7:0] len,
                          input logic [1:0] be);
    int n = 0;
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_len = len; cmd_be = be;
    while (!cmd_ready && n < 50) begin @(posedge clk); #2; n++; end
    if (!cmd_ready) fail_now("cmd_accept_timeout");
    @(posedge clk); #2;
    cmd_valid = 1'b0;
    chk("busy_after_accept", {31'b0, busy}, 1);
    chk("cmd_ready_after_accept", {31'b0, cmd_ready}, 0);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 100) begin @(posedge clk); #2; n++; end
    if (busy) fail_now(name);
  endtask

  task automatic write_burst(input logic [15:0] a, input logic [7:0] len,
                             input logic [1:0] be, input logic toggle);
    int idx = 0;
    int n = 0;
    logic ph = 1'b0;
    xact_t e;
    clear_logs();
    for (int i = 0; i <= int'(len); i++) begin
      e.a = 16'(a + i); e.d = wd(i); e.be = be;
      exp_wr.push_back(e);
    end
    send_cmd(1'b1, a, len, be);
    while (idx <= int'(len) && n < 4000) begin
      wdata = wd(idx);
      wdata_valid = toggle ? ph : 1'b1;
      ph = ~ph;
      if (wdata_valid && wdata_ready) idx++;
      @(posedge clk); #2;
      n++;
    end
    wdata_valid = 1'b0;
    if (idx <= int'(len)) fail_now("wr_feed_timeout");
    wait_idle("wr_idle_timeout");
    chk("wr_pulse_count", obs_wr_addr.size(), int'(len) + 1);
    chk("wr_expect_drained", exp_wr.size(), 0);
    if (wr_cyc.size() > 0) chk("busy_fall_after_last_wr", cyc - wr_cyc[$], 1);
  endtask

  task automatic read_burst(input logic [15:0] a, input logic [7:0] len,
                            input logic [1:0] be, input int stall, input logic poke_cmd);
    int got = 0;
    int n = 0;
    int held = 0;
    xact_t e;
    clear_logs();
    for (int i = 0; i <= int'(len); i++) begin
      e.a = 16'(a + i); e.d = 16'h0; e.be = be;
      exp_rd.push_back(e);
      exp_rdata.push_back(rd_model(16'(a + i)));
    end
    send_cmd(1'b0, a, len, be);
    while (got <= int'(len) && n < 500) begin
      wdata_valid = 1'($urandom_range(0, 1));
      cmd_valid = 1'b0;
      if (rdata_valid) begin
        if (held < stall) begin
          rdata_ready = 1'b0;
          held++;
          if (poke_cmd) begin cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 16'hDEAD; end
        end else rdata_ready = 1'b1;
        if (rdata_ready) begin got++; held = 0; end
      end else rdata_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #2;
      n++;
    end
    rdata_ready = 1'b0; wdata_valid = 1'b0; cmd_valid = 1'b0;
    if (got <= int'(len)) fail_now("rd_drain_timeout");
    wait_idle("rd_idle_timeout");
    chk("rd_strobe_count", obs_rd_addr.size(), int'(len) + 1);
    chk("rd_expect_drained", exp_rd.size() + exp_rdata.size(), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cmd_ready"}, {31'b0, cmd_ready}, 0);
    chk({tag, "_wdata_ready"}, {31'b0, wdata_ready}, 0);
    chk({tag, "_rdata_valid"}, {31'b0, rdata_valid}, 0);
    chk({tag, "_rdata"}, {16'b0, rdata}, 0);
    chk({tag, "_busy"}, {31'b0, busy}, 0);
    chk({tag, "_strobes"}, {29'b0, mpu_en, mpu_rd, mpu_wr}, 0);
    chk({tag, "_mpu_be"}, {30'b0, mpu_be}, 0);
    chk({tag, "_mpu_addr"}, {16'b0, mpu_addr}, 0);
    chk({tag, "_mpu_wdata"}, {16'b0, mpu_wdata}, 0);
  endtask

  initial begin
    _reset = 1'b0;
    cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_be = '0;
    wdata_valid = 1'b0; wdata = '0; rdata_ready = 1'b0;
    #1;
    chk_all_zero("por");
    @(posedge clk); #2;
    @(posedge clk); #2;
    _reset = 1'b1;
    #1;
    chk("cmd_ready_low_at_release", {31'b0, cmd_ready}, 0);
    @(posedge clk); #2;
    chk("cmd_ready_after_release", {31'b0, cmd_ready}, 1);

    // Three-word write with data always offered: pulses two cycles apart.
    write_burst(16'h0010, 8'd2, 2'b11, 1'b0);
    if (obs_wr_addr.size() == 3) begin
      chk("lit_wr_addr0", {16'b0, obs_wr_addr[0]}, 32'h0010);
      chk("lit_wr_addr2", {16'b0, obs_wr_addr[2]}, 32'h0012);
      chk("lit_wr_data0", {16'b0, obs_wr_data[0]}, 32'h1111);
      chk("lit_wr_data2", {16'b0, obs_wr_data[2]}, 32'h3333);
      chk("wr_gap01", wr_cyc[1] - wr_cyc[0], 2);
      chk("wr_gap12", wr_cyc[2] - wr_cyc[1], 2);
    end else fail_now("lit_wr_pulses");
    chk("busy_low_after_write", {31'b0, busy}, 0);

    read_burst(16'h4000, 8'd1, 2'b11, 0, 1'b0);
    if (obs_rdata.size() == 2) begin
      chk("lit_rdata0", {16'b0, obs_rdata[0]}, 32'hE000);
      chk("lit_rdata1", {16'b0, obs_rdata[1]}, 32'hE001);
    end else fail_now("lit_rdata_count");

    // Backpressure with a command offered while busy.
    read_burst(16'h0100, 8'd2, 2'b10, 5, 1'b1);
    if (obs_rdata.size() == 3) chk("lit_bp_rdata0", {16'b0, obs_rdata[0]}, 32'hA100);
    else fail_now("lit_bp_rdata_count");

    read_burst(16'hFFFF, 8'd1, 2'b01, 1, 1'b0);
    if (obs_rd_addr.size() == 2) begin
      chk("lit_wrap_addr1", {16'b0, obs_rd_addr[1]}, 32'h0000);
      chk("lit_wrap_rdata1", {16'b0, obs_rdata[1]}, 32'hA000);
    end else fail_now("lit_wrap_count");

    write_burst(16'h8000, 8'd255, 2'b10, 1'b1);
    chk("maxlen_no_rd", obs_rd_addr.size(), 0);
    if (obs_wr_addr.size() == 256)
      chk("lit_maxlen_last_addr", {16'b0, obs_wr_addr[255]}, 32'h80FF);

    // Asynchronous reset while a read strobe is on the bus.
    exp_rd.delete(); exp_rdata.delete();
    e_push_reset_read();
    chk("rd_active_before_reset", {31'b0, mpu_rd}, 1);
    cmd_valid = 1'($urandom_range(0, 1)); wdata_valid = 1'b1;
    wdata = 16'($urandom); rdata_ready = 1'($urandom_range(0, 1));
    #1;
    _reset = 1'b0;
    #1;
    chk_all_zero("midrst");
    exp_rd.delete(); exp_rdata.delete();
    @(posedge clk); #2;
    cmd_valid = 1'b0; wdata_valid = 1'b0; rdata_ready = 1'b0;
    _reset = 1'b1;
    @(posedge clk); #2;
    chk("cmd_ready_after_midrst", {31'b0, cmd_ready}, 1);
    chk("busy_after_midrst", {31'b0, busy}, 0);

    write_burst(16'h0001, 8'd0, 2'b01, 1'b0);
    if (obs_wr_addr.size() == 1) chk("lit_single_wr_addr", {16'b0, obs_wr_addr[0]}, 32'h0001);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  task automatic e_push_reset_read();
    xact_t e;
    e.a = 16'h1234; e.d = 16'h0; e.be = 2'b01;
    exp_rd.push_back(e);
    send_cmd(1'b0, 16'h1234, 8'd3, 2'b01);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
